// File: rtl/jtroadf_romarb_pkg.sv
// jtroadf_romarb_pkg
// Shared encodings for the scroll/object ROM arbiter:
//   state_t    arbiter FSM state (2 bits)
//   owner_t    which requester owns the outstanding SDRAM fetch
//   region_bit SDRAM address bit that selects scroll (0) or object (1) space
package jtroadf_romarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_SCR = 1'b0,
        OWN_OBJ = 1'b1
    } owner_t;

    function automatic int region_bit(input int aw);
        return aw - 1;
    endfunction

endpackage

// File: rtl/jtroadf_romarb_slot.sv
// jtroadf_romarb_slot
// Single-entry cache for one requester of the ROM arbiter.
// Ports:
//   rst, clk        asynchronous active-high reset, clock
//   cs, addr        requester enable and word address
//   data            cached word (registered)
//   ok              data valid for the current addr (combinational hit)
//   pending         requester wants a word that is not cached
//   wr_en, wr_tag,  fill port driven by the arbiter when its fetch
//   wr_data         for this slot completes
module jtroadf_romarb_slot #(
    parameter int TW = 13,
    parameter int DW = 32
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cs,
    input  logic [TW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          ok,
    output logic          pending,
    input  logic          wr_en,
    input  logic [TW-1:0] wr_tag,
    input  logic [DW-1:0] wr_data
);

    logic [TW-1:0] tag;
    logic          valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else if (wr_en) begin
            tag   <= wr_tag;
            data  <= wr_data;
            valid <= 1'b1;
        end
    end

    // Hit is zero-latency; a requester that moves its address simply misses.
    assign ok      = cs & valid & (addr == tag);
    assign pending = cs & ~ok;

endmodule

// File: rtl/jtroadf_romarb.sv
// jtroadf_romarb
// Shares one 32-bit SDRAM ROM slot between the scroll layer (time critical)
// and the object layer. Each requester has a single-entry cache; misses are
// fetched one at a time through an IDLE -> ISSUE -> WAIT sequence.
// Ports:
//   rst, clk                      asynchronous active-high reset, clock
//   scr_cs/addr/data/ok           scroll requester port
//   obj_cs/addr/data/ok           object requester port
//   rom_cs/addr/data/ok           SDRAM bank port
// Build option: define JTROADF_ROMARB_RR_EN to alternate grants when both
// requesters miss at once; otherwise scroll has fixed priority.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | rom_cs low, pick a pending requester and latch its address
// ST_ISSUE | rom_cs high, rom_ok ignored (may be stale from last address)
// ST_WAIT  | rom_cs high, capture rom_data into the owner's cache on rom_ok
module jtroadf_romarb
    import jtroadf_romarb_pkg::*;
#(
    parameter int SW = 13,
    parameter int OW = 14,
    parameter int AW = 15,
    parameter int DW = 32
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          scr_cs,
    input  logic [SW-1:0] scr_addr,
    output logic [DW-1:0] scr_data,
    output logic          scr_ok,
    input  logic          obj_cs,
    input  logic [OW-1:0] obj_addr,
    output logic [DW-1:0] obj_data,
    output logic          obj_ok,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok
);

    localparam int RB = region_bit(AW);

    state_t        state;
    owner_t        owner;
    logic          scr_pend, obj_pend, grant_obj;
    logic          scr_wr, obj_wr;
    logic [AW-1:0] scr_rom, obj_rom;

    always_comb begin
        scr_rom     = AW'(scr_addr);
        scr_rom[RB] = 1'b0;
        obj_rom     = AW'(obj_addr);
        obj_rom[RB] = 1'b1;
    end

`ifdef JTROADF_ROMARB_RR_EN
    owner_t last_owner;
    assign grant_obj = obj_pend & (~scr_pend | (last_owner == OWN_SCR));
`else
    assign grant_obj = obj_pend & ~scr_pend;
`endif

    assign scr_wr = (state == ST_WAIT) && rom_ok && (owner == OWN_SCR);
    assign obj_wr = (state == ST_WAIT) && rom_ok && (owner == OWN_OBJ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_SCR;
            rom_cs     <= 1'b0;
            rom_addr   <= '0;
`ifdef JTROADF_ROMARB_RR_EN
            last_owner <= OWN_OBJ;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scr_pend || obj_pend) begin
                        rom_cs <= 1'b1;
                        state  <= ST_ISSUE;
                        if (grant_obj) begin
                            owner    <= OWN_OBJ;
                            rom_addr <= obj_rom;
                        end else begin
                            owner    <= OWN_SCR;
                            rom_addr <= scr_rom;
                        end
`ifdef JTROADF_ROMARB_RR_EN
                        last_owner <= grant_obj ? OWN_OBJ : OWN_SCR;
`endif
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (rom_ok) begin
                        rom_cs <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    rom_cs <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // rom_addr is held for the whole fetch, so its low bits double as the
    // fetch tag written into the owner's cache.
    jtroadf_romarb_slot #(.TW(SW), .DW(DW)) u_scr (
        .rst     (rst),
        .clk     (clk),
        .cs      (scr_cs),
        .addr    (scr_addr),
        .data    (scr_data),
        .ok      (scr_ok),
        .pending (scr_pend),
        .wr_en   (scr_wr),
        .wr_tag  (rom_addr[SW-1:0]),
        .wr_data (rom_data)
    );

    jtroadf_romarb_slot #(.TW(OW), .DW(DW)) u_obj (
        .rst     (rst),
        .clk     (clk),
        .cs      (obj_cs),
        .addr    (obj_addr),
        .data    (obj_data),
        .ok      (obj_ok),
        .pending (obj_pend),
        .wr_en   (obj_wr),
        .wr_tag  (rom_addr[OW-1:0]),
        .wr_data (rom_data)
    );

endmodule

// File: tb/tb_jtroadf_romarb.sv
// tb_jtroadf_romarb
// Bench for the scroll/object ROM arbiter: a behavioural SDRAM with random
// latency, a word-level cache model of both requesters and a grant log.
module tb_jtroadf_romarb;

    localparam int SW = 13, OW = 14, AW = 15, DW = 32;

    logic          rst = 1'b1, clk = 1'b0;
    logic          scr_cs = 1'b0, obj_cs = 1'b0;
    logic [SW-1:0] scr_addr = '0;
    logic [OW-1:0] obj_addr = '0;
    logic [DW-1:0] scr_data, obj_data;
    logic          scr_ok, obj_ok;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          rom_ok = 1'b0;

    jtroadf_romarb dut (
        .rst(rst), .clk(clk),
        .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        n_chk++;
        if (obsv !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obsv, expv, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        if (a == 15'h0155) return 32'hDEADBEEF;
        return {a, 2'b10, ~a};
    endfunction

    function automatic logic [AW-1:0] scr_map(input logic [SW-1:0] a);
        return {2'b00, a};
    endfunction

    function automatic logic [AW-1:0] obj_map(input logic [OW-1:0] a);
        return {1'b1, a};
    endfunction

    // model: cached ROM word per requester (0 = scroll, 1 = object)
    bit            m_val[2];
    logic [AW-1:0] m_tag[2];
    // SDRAM model
    int            cnt = 0, lat = 2, force_lat = 4, stale_mode = 1;
    bit            stale = 0, real_ok = 0, prev_cs = 0;
    logic [AW-1:0] cur = '0, prev_addr = '0;
    // arbitration model
    bit            pend_s_q = 0, pend_o_q = 0, last_obj = 1;
    logic [AW-1:0] s_rom_q = '0, o_rom_q = '0, exp_addr;
    logic [AW-1:0] glog[$];

    always @(negedge clk) begin
        if (rst) begin
            check_val("rst_rom_cs", 32'(rom_cs), 32'd0);
            check_val("rst_rom_addr", 32'(rom_addr), 32'd0);
            check_val("rst_scr_ok", 32'(scr_ok), 32'd0);
            check_val("rst_obj_ok", 32'(obj_ok), 32'd0);
            check_val("rst_scr_data", scr_data, 32'd0);
            check_val("rst_obj_data", obj_data, 32'd0);
            m_val[0] = 0; m_val[1] = 0;
            rom_ok = 0; real_ok = 0; cnt = 0; prev_cs = 0;
            pend_s_q = 0; pend_o_q = 0; last_obj = 1;
        end else begin
            if (rom_ok && real_ok) begin
                m_val[cur[AW-1]] = 1;
                m_tag[cur[AW-1]] = cur;
            end
            begin : chk_ok
                bit es, eo;
                es = scr_cs && m_val[0] && (m_tag[0] == scr_map(scr_addr));
                eo = obj_cs && m_val[1] && (m_tag[1] == obj_map(obj_addr));
                check_val("scr_ok", 32'(scr_ok), 32'(es));
                check_val("obj_ok", 32'(obj_ok), 32'(eo));
                if (es) check_val("scr_data", scr_data, mem(m_tag[0]));
                if (eo) check_val("obj_data", obj_data, mem(m_tag[1]));
            end
            if (!prev_cs) begin
                // previous cycle was idle: a request must follow iff something missed
                check_val("grant", 32'(rom_cs), 32'(pend_s_q | pend_o_q));
                if (rom_cs) begin
                    bit pick_obj;
`ifdef JTROADF_ROMARB_RR_EN
                    pick_obj = pend_o_q && (!pend_s_q || !last_obj);
`else
                    pick_obj = pend_o_q && !pend_s_q;
`endif
                    exp_addr = pick_obj ? o_rom_q : s_rom_q;
                    check_val("grant_addr", 32'(rom_addr), 32'(exp_addr));
                    last_obj = pick_obj;
                    glog.push_back(rom_addr);
                end
            end else if (rom_cs) begin
                check_val("addr_hold", 32'(rom_addr), 32'(prev_addr));
            end
            // SDRAM response; a stale ok with junk data may show up in ISSUE
            if (rom_cs) begin
                if (!prev_cs) begin
                    cnt   = 1;
                    lat   = (force_lat != 0) ? force_lat : int'($urandom_range(2, 5));
                    stale = (stale_mode == 2) || (stale_mode == 0 && $urandom_range(0, 2) == 0);
                end else cnt++;
            end else cnt = 0;
            real_ok  = rom_cs && (cnt >= lat);
            rom_ok   = real_ok || (rom_cs && cnt == 1 && stale);
            rom_data = real_ok ? mem(rom_addr) : 32'hBAD0BAD0;
            cur      = rom_addr;
            prev_cs  = rom_cs;
            prev_addr = rom_addr;
            s_rom_q  = scr_map(scr_addr);
            o_rom_q  = obj_map(obj_addr);
            pend_s_q = scr_cs && !(m_val[0] && m_tag[0] == s_rom_q);
            pend_o_q = obj_cs && !(m_val[1] && m_tag[1] == o_rom_q);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ok(input bit is_obj, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if ((is_obj ? obj_ok : scr_ok) === 1'b1) break;
            tick(1);
        end
        check_val(tag, 32'(is_obj ? obj_ok : scr_ok), 32'd1);
    endtask

    task automatic wait_cs(input bit level, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (rom_cs === level) break;
            tick(1);
        end
        check_val(tag, 32'(rom_cs), 32'(level));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] g;
        bit            obj_seen;
        tick(3);
        rst = 1'b0;

        // first miss, SDRAM ok four cycles into the request
        scr_cs = 1; scr_addr = 13'h0155;
        wait_ok(0, 50, "t1_ok");
        check_val("t1_data", scr_data, 32'hDEADBEEF);
        check_val("t1_addr", 32'(glog[0]), 32'h0155);
        tick(1);
        check_val("t1_cs_idle", 32'(rom_cs), 32'd0);

        // hit: no traffic for 100 cycles
        glog.delete();
        tick(100);
        check_val("t2_no_req", 32'(glog.size()), 32'd0);
        check_val("t2_ok", 32'(scr_ok), 32'd1);

        // simultaneous misses from reset
        rst = 1; glog.delete();
        scr_addr = 13'h0010; obj_cs = 1; obj_addr = 14'h2000;
        tick(2);
        rst = 0;
        wait_ok(1, 100, "t3_obj_ok");
        wait_ok(0, 100, "t3_scr_ok");
        check_val("t3_first", 32'(glog[0]), 32'h0010);
        check_val("t3_second", 32'(glog[1]), 32'h6000);
        check_val("t3_scr_data", scr_data, mem(15'h0010));
        check_val("t3_obj_data", obj_data, mem(15'h6000));

        // address moves while the fetch is in WAIT
        obj_cs = 0; force_lat = 6; glog.delete();
        scr_addr = 13'h0020;
        wait_cs(1, 20, "t4_req");
        tick(2);
        scr_addr = 13'h0021;
        wait_cs(0, 20, "t4_done");
        check_val("t4_old_ok", 32'(scr_ok), 32'd0);
        wait_ok(0, 50, "t4_ok");
        check_val("t4_refetch", 32'(glog[1]), 32'h0021);
        check_val("t4_data", scr_data, mem(15'h0021));

        // stale ok during ISSUE must be ignored
        force_lat = 3; stale_mode = 2;
        scr_addr = 13'h0100;
        tick(1);
        wait_ok(0, 50, "t5_ok");
        check_val("t5_data", scr_data, mem(15'h0100));

        // reset in the middle of a fetch
        force_lat = 8; stale_mode = 1;
        scr_addr = 13'h0200;
        tick(1);
        wait_cs(1, 20, "t6_req");
        tick(3);
        rst = 1;
        tick(1);
        check_val("t6_rst_cs", 32'(rom_cs), 32'd0);
        check_val("t6_rst_ok", 32'(scr_ok), 32'd0);
        rst = 0;
        wait_ok(0, 50, "t6_ok");
        check_val("t6_data", scr_data, mem(15'h0200));

        // random traffic against the model
        force_lat = 0; stale_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) scr_cs = ~scr_cs;
            if ($urandom_range(0, 7) == 0) obj_cs = ~obj_cs;
            if ($urandom_range(0, 5) == 0) scr_addr = 13'h0400 | 13'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) obj_addr = 14'h1000 | 14'($urandom_range(0, 3));
            tick(1);
        end

        // both requesters always missing
        force_lat = 2; stale_mode = 1;
        rst = 1; scr_cs = 1; obj_cs = 1; scr_addr = 13'h0300; obj_addr = 14'h1300;
        tick(2);
        glog.delete();
        rst = 0;
        obj_seen = 0;
        for (int i = 0; i < 600 && glog.size() < 10; i++) begin
            if (obj_ok) obj_seen = 1;
            if (scr_ok) scr_addr = scr_addr + 13'd1;
            if (obj_ok) obj_addr = obj_addr + 14'd1;
            tick(1);
        end
        check_val("t8_count", 32'(glog.size() >= 10), 32'd1);
        for (int i = 0; i < 10; i++) begin
            g = glog[i];
`ifdef JTROADF_ROMARB_RR_EN
            check_val("t8_alternate", 32'(g[AW-1]), 32'(i % 2));
`else
            check_val("t8_scr_only", 32'(g[AW-1]), 32'd0);
`endif
        end
`ifdef JTROADF_ROMARB_RR_EN
        check_val("t8_obj_served", 32'(obj_seen), 32'd1);
`else
        check_val("t8_obj_starved", 32'(obj_seen | obj_ok), 32'd0);
`endif

        scr_cs = 0; obj_cs = 0;
        tick(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
